sync_dual_port_sram_param: RTL and testbench
============================================

// Module: sync_dual_port_sram_param
// PURPOSE
//  Parametrised successor of the fixed 16x8 sync dual-port RAM: one write port, one read port, one clock.
//  Adds per-lane write enables, a selectable read-during-write mode and an optional output register.
//  A post-reset clear sequencer sets every word to CLEAR_VAL, so contents are never undefined after reset.
//  Used as the generic on-chip buffer RAM under FIFOs and line buffers.
// PARAMETERS
//  DATA_W    16  word width; must be a multiple of LANE_W
//  LANE_W     8  write-enable granularity; NLANE = DATA_W/LANE_W
//  ADDR_W     4  address width
//  DEPTH     16  number of words; DEPTH <= 2**ADDR_W
//  RDW_MODE   0  same-address read+write: 0 = old data, 1 = new data (write-through)
//  OUT_REG    0  0 = read latency 1; 1 = extra output register, latency 2
//  CLEAR_VAL  0  value written to every word by the clear sequencer
// PORTS
//  clk     in   1       clock; all logic on posedge
//  rst     in   1       synchronous reset, active-low
//  we      in   1       write enable
//  w_be    in   NLANE   lane enables; bit k gates data_w[k*LANE_W +: LANE_W]
//  w_addr  in   ADDR_W  write address
//  data_w  in   DATA_W  write data
//  en      in   1       read enable
//  r_addr  in   ADDR_W  read address
//  data_r  out  DATA_W  read data; holds its last value between reads
//  r_valid out  1       one-cycle strobe, aligned with new data_r
//  r_err   out  1       aligned with r_valid: read address >= DEPTH
//  busy    out  1       clear in progress; we/en ignored
// BEHAVIOUR
//  Reset (rst==0 at posedge): state=CLEAR, clr_cnt=0, data_r=0, r_valid=0, r_err=0, busy=1, pipe regs=0.
//  FSM: CLEAR -> IDLE. Runs only while rst==1.
//  - CLEAR writes CLEAR_VAL to mem[clr_cnt], then clr_cnt++.
//  - On the cycle clr_cnt==DEPTH-1: next state IDLE; busy falls at that edge. busy is high for exactly DEPTH cycles after rst release.
//  - rst low mid-CLEAR restarts the clear from 0.
//  In CLEAR, we/en are dropped, not queued: no write, r_valid stays 0.
//  In IDLE:
//  - Write: we=1 at posedge updates only lanes with w_be=1. w_be=0 is a no-op.
//  - Read: en=1 at edge N gives data_r, r_valid=1 after edge N+1 (OUT_REG=0) or N+2 (OUT_REG=1). Back-to-back reads at full rate.
//  - Read and write to the same address in one cycle:
//      RDW_MODE=0 returns the pre-write word.
//      RDW_MODE=1 returns enabled lanes from data_w, other lanes from the old word.
//  - Address >= DEPTH: write dropped; read returns 0 with r_valid=1 and r_err=1.
//  - Address wrap: none; the address is never masked or folded.
//  - X/Z on an address with its enable low: no effect.
//  Widths: clr_cnt is ADDR_W+1 bits (handles DEPTH=2**ADDR_W); lane merge is a pure bit select.
// STRUCTURE
//  sram_pkg.vh (shared include): RDW_OLD/RDW_NEW constants, ST_CLEAR/ST_IDLE encodings, NLANE derivation macro.
//  Sub-module sram_clear_ctrl:
//  - owns the FSM and clr_cnt
//  - outputs busy, clr_we, clr_addr
//  - top muxes its write onto the array port.
//  Top: storage array, lane-merge write, RDW bypass mux, optional OUT_REG stage; r_valid/r_err pipelined with data.
// TESTING (defaults unless stated)
//  1 Clear: hold rst=0 2 cycles, release -> busy=1 for exactly 16 cycles; read 0..15 -> 16'h0000, r_err=0.
//  2 Fill/read: write 16'hA500+i to addr i (i=0..15, w_be=2'b11), read 0..15 back-to-back
//    -> data_r=16'hA500+i, r_valid one cycle after each en.
//  3 Lanes: write 16'h1234 to addr 3, then 16'hABCD with w_be=2'b10 -> read addr 3 = 16'hAB34.
//  4 RDW: addr 5=16'h1111; same cycle write 16'h2222 and read addr 5
//    -> RDW_MODE=0: 16'h1111, next read 16'h2222; RDW_MODE=1: 16'h2222.
//  5 Range, DEPTH=12: write addr 13 dropped; read 13 -> 0, r_err=1; read 11 -> written value, r_err=0.
//  6 Mid-clear reset + OUT_REG=1:
//    - rst=0 at clear cycle 7 -> busy high 16 cycles after re-release.
//    - we/en during busy -> no write, no r_valid.
//    - Then a read returns data 2 cycles after en.

Source files
------------

// File: rtl/sync_dual_port_sram_param_pkg.sv
// Shared definitions for the parametrised dual-port SRAM and its clear sequencer.
// Holds the read-during-write mode constants, the clear-FSM state encoding and
// the helper that derives the number of write lanes from the word and lane widths.
package sync_dual_port_sram_param_pkg;

  // Same-address read-during-write behaviour selectors
  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  // Clear sequencer states: CLEAR walks the array after reset, IDLE hands the
  // array port over to the user write port
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } clrState_e;

  // Number of independently enabled write lanes in one word
  function automatic int laneCount(input int dataW, input int laneW);
    return dataW / laneW;
  endfunction

endpackage

// File: rtl/sync_dual_port_sram_param_clear_ctrl.sv
// Post-reset clear sequencer for sync_dual_port_sram_param.
// After the synchronous active-low reset is released it steps through every
// word address once, asking the top to write the clear value, then goes idle.
// Ports:
//   clk      in   clock, all logic on posedge
//   rst      in   synchronous reset, active-low; low mid-clear restarts from 0
//   busy     out  high while the clear is running (registered)
//   clr_we   out  clear write strobe for the array port
//   clr_addr out  address being cleared
module sram_clear_ctrl
  import sync_dual_port_sram_param_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  // The counter carries one extra bit so DEPTH == 2**ADDR_W stays representable
  localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'(DEPTH - 1);

  clrState_e         state_q;
  logic [ADDR_W:0]   clrCnt_q;
  logic              busy_q;

  // Clear FSM: reset parks it in CLEAR at address 0 with busy raised. Each
  // cycle in CLEAR clears one word; the edge that clears the last word moves
  // to IDLE and drops busy, so busy spans exactly DEPTH cycles after release.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_CLEAR;
      clrCnt_q <= '0;
      busy_q   <= 1'b1;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          if (clrCnt_q == LAST_ADDR) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            clrCnt_q <= clrCnt_q + 1'b1;
          end
        end
        ST_IDLE: begin
          busy_q <= 1'b0;
        end
        default: begin
          state_q <= ST_CLEAR;
        end
      endcase
    end
  end

  // The clear write is suppressed while reset is asserted so a held reset
  // never touches the array
  assign busy     = busy_q;
  assign clr_we   = rst && (state_q == ST_CLEAR);
  assign clr_addr = clrCnt_q[ADDR_W-1:0];

endmodule

// File: rtl/sync_dual_port_sram_param.sv
// Parametrised single-clock dual-port RAM: one write port with per-lane
// enables, one read port with selectable read-during-write behaviour and an
// optional output register. Contents are cleared to CLEAR_VAL after reset.
// Ports:
//   clk     in   clock
//   rst     in   synchronous reset, active-low
//   we      in   write enable
//   w_be    in   lane enables, bit k gates data_w[k*LANE_W +: LANE_W]
//   w_addr  in   write address
//   data_w  in   write data
//   en      in   read enable
//   r_addr  in   read address
//   data_r  out  read data, holds between reads
//   r_valid out  one-cycle strobe with each new data_r
//   r_err   out  with r_valid: the read address was out of range
//   busy    out  clear in progress, we/en ignored
module sync_dual_port_sram_param
  import sync_dual_port_sram_param_pkg::*;
#(
  parameter int              DATA_W    = 16,
  parameter int              LANE_W    = 8,
  parameter int              ADDR_W    = 4,
  parameter int              DEPTH     = 16,
  parameter int              RDW_MODE  = RDW_OLD,
  parameter int              OUT_REG   = 0,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                we,
  input  logic [laneCount(DATA_W, LANE_W)-1:0] w_be,
  input  logic [ADDR_W-1:0]                   w_addr,
  input  logic [DATA_W-1:0]                   data_w,
  input  logic                                en,
  input  logic [ADDR_W-1:0]                   r_addr,
  output logic [DATA_W-1:0]                   data_r,
  output logic                                r_valid,
  output logic                                r_err,
  output logic                                busy
);

  localparam int              NLANE     = laneCount(DATA_W, LANE_W);
  localparam int              IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(DEPTH);

  logic              clrWe;
  logic [ADDR_W-1:0] clrAddr;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              wrInRange;
  logic              rdInRange;
  logic              wrFire;
  logic              rdFire;
  logic [IDX_W-1:0]  wrIdx;
  logic [IDX_W-1:0]  rdIdx;
  logic [IDX_W-1:0]  clrIdx;
  logic [DATA_W-1:0] rdWord;

  logic [DATA_W-1:0] rdData_q;
  logic              rdValid_q;
  logic              rdErr_q;

  sram_clear_ctrl #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) uClearCtrl (
    .clk      (clk),
    .rst      (rst),
    .busy     (busy),
    .clr_we   (clrWe),
    .clr_addr (clrAddr)
  );

  // Addresses are never folded: anything at or beyond DEPTH is simply out of
  // range, and only in-range addresses are narrowed to the array index
  assign wrInRange = {1'b0, w_addr} < DEPTH_EXT;
  assign rdInRange = {1'b0, r_addr} < DEPTH_EXT;
  assign wrIdx     = w_addr[IDX_W-1:0];
  assign rdIdx     = r_addr[IDX_W-1:0];
  assign clrIdx    = clrAddr[IDX_W-1:0];
  assign wrFire    = rst && !busy && we && wrInRange;
  assign rdFire    = rst && !busy && en;

  // Single array write port: the clear sequencer owns it while running,
  // otherwise user writes land lane by lane under w_be
  always_ff @(posedge clk) begin
    if (clrWe) begin
      mem[clrIdx] <= CLEAR_VAL;
    end else if (wrFire) begin
      for (int k = 0; k < NLANE; k++) begin
        if (w_be[k]) begin
          mem[wrIdx][k*LANE_W +: LANE_W] <= data_w[k*LANE_W +: LANE_W];
        end
      end
    end
  end

  // Read word selection: out-of-range reads return zero. In write-through
  // mode a same-address write overlays its enabled lanes on the stored word;
  // otherwise the stored (pre-write) word is returned.
  always_comb begin
    rdWord = '0;
    if (rdInRange) begin
      rdWord = mem[rdIdx];
      if ((RDW_MODE == RDW_NEW) && wrFire && (w_addr == r_addr)) begin
        for (int k = 0; k < NLANE; k++) begin
          if (w_be[k]) begin
            rdWord[k*LANE_W +: LANE_W] = data_w[k*LANE_W +: LANE_W];
          end
        end
      end
    end
  end

  // First read stage: captures the word on each accepted read and keeps it
  // otherwise; valid and error travel alongside it
  always_ff @(posedge clk) begin
    if (!rst) begin
      rdData_q  <= '0;
      rdValid_q <= 1'b0;
      rdErr_q   <= 1'b0;
    end else begin
      rdValid_q <= rdFire;
      rdErr_q   <= rdFire && !rdInRange;
      if (rdFire) begin
        rdData_q <= rdWord;
      end
    end
  end

  // Optional second stage adds one cycle of latency while keeping data,
  // valid and error aligned
  if (OUT_REG != 0) begin : gOutReg
    logic [DATA_W-1:0] outData_q;
    logic              outValid_q;
    logic              outErr_q;

    always_ff @(posedge clk) begin
      if (!rst) begin
        outData_q  <= '0;
        outValid_q <= 1'b0;
        outErr_q   <= 1'b0;
      end else begin
        outValid_q <= rdValid_q;
        outErr_q   <= rdErr_q;
        if (rdValid_q) begin
          outData_q <= rdData_q;
        end
      end
    end

    assign data_r  = outData_q;
    assign r_valid = outValid_q;
    assign r_err   = outErr_q;
  end else begin : gNoOutReg
    assign data_r  = rdData_q;
    assign r_valid = rdValid_q;
    assign r_err   = rdErr_q;
  end

endmodule

// File: tb/tb_sync_dual_port_sram_param.sv
// Directed self-checking bench for sync_dual_port_sram_param.
// Three instances share one stimulus stream:
//   uA  defaults (old-data read-during-write, latency 1, DEPTH 16)
//   uB  write-through read-during-write, DEPTH 12
//   uC  output register enabled (latency 2), DEPTH 16
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_sync_dual_port_sram_param;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        we = 1'b0;
  logic        en = 1'b0;
  logic [1:0]  wBe = '0;
  logic [3:0]  wAddr = '0;
  logic [3:0]  rAddr = '0;
  logic [15:0] wData = '0;

  logic [15:0] aData, bData, cData;
  logic        aValid, bValid, cValid;
  logic        aErr, bErr, cErr;
  logic        aBusy, bBusy, cBusy;

  int checks = 0;
  int failures = 0;

  int nA, nB, nC, validSeen;

  always #5 clk = ~clk;

  sync_dual_port_sram_param uA (
    .clk(clk), .rst(rst), .we(we), .w_be(wBe), .w_addr(wAddr), .data_w(wData),
    .en(en), .r_addr(rAddr), .data_r(aData), .r_valid(aValid), .r_err(aErr), .busy(aBusy)
  );

  sync_dual_port_sram_param #(.RDW_MODE(1), .DEPTH(12)) uB (
    .clk(clk), .rst(rst), .we(we), .w_be(wBe), .w_addr(wAddr), .data_w(wData),
    .en(en), .r_addr(rAddr), .data_r(bData), .r_valid(bValid), .r_err(bErr), .busy(bBusy)
  );

  sync_dual_port_sram_param #(.OUT_REG(1)) uC (
    .clk(clk), .rst(rst), .we(we), .w_be(wBe), .w_addr(wAddr), .data_w(wData),
    .en(en), .r_addr(rAddr), .data_r(cData), .r_valid(cValid), .r_err(cErr), .busy(cBusy)
  );

  // Compare one observed value against its hand-computed expectation
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs and return at the next falling edge
  task automatic applyStimulus(input logic iWe, input logic [1:0] iBe, input logic [3:0] iWa,
                               input logic [15:0] iWd, input logic iEn, input logic [3:0] iRa);
    we    = iWe;
    wBe   = iBe;
    wAddr = iWa;
    wData = iWd;
    en    = iEn;
    rAddr = iRa;
    @(negedge clk);
  endtask

  // After a reset release, record the cycle on which each busy falls and
  // count read strobes from uA/uC; any pending we/en is dropped once uA and
  // uC have both finished clearing
  task automatic measureClear(output int oA, output int oB, output int oC, output int oValid);
    oA = 0; oB = 0; oC = 0; oValid = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (oA == 0 && !aBusy) oA = i;
      if (oB == 0 && !bBusy) oB = i;
      if (oC == 0 && !cBusy) oC = i;
      if (aValid || cValid) oValid++;
      if (oA != 0 && oC != 0) begin
        we = 1'b0;
        en = 1'b0;
      end
    end
  endtask

  initial begin
    // Reset state and clear duration
    repeat (2) @(negedge clk);
    checkOutput("reset_busyA", aBusy, 1);
    checkOutput("reset_busyC", cBusy, 1);
    checkOutput("reset_validA", aValid, 0);
    checkOutput("reset_dataA", aData, 0);
    checkOutput("reset_errA", aErr, 0);
    checkOutput("reset_dataC", cData, 0);
    rst = 1'b1;
    measureClear(nA, nB, nC, validSeen);
    checkOutput("clear_cyclesA", nA, 16);
    checkOutput("clear_cyclesB", nB, 12);
    checkOutput("clear_cyclesC", nC, 16);
    checkOutput("clear_noValid", validSeen, 0);

    for (int i = 0; i < 16; i++) begin
      applyStimulus(0, 2'b00, 4'd0, 16'h0, 1, 4'(i));
      checkOutput($sformatf("clear_data%0d", i), aData, 16'h0000);
      checkOutput($sformatf("clear_err%0d", i), aErr, 0);
    end
    applyStimulus(0, 2'b00, 4'd0, 16'h0, 0, 4'd0);

    // Fill then back-to-back reads
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1, 2'b11, 4'(i), 16'hA500 + 16'(i), 0, 4'd0);
    end
    for (int i = 0; i < 16; i++) begin
      applyStimulus(0, 2'b00, 4'd0, 16'h0, 1, 4'(i));
      checkOutput($sformatf("fill_data%0d", i), aData, 16'hA500 + 16'(i));
      checkOutput($sformatf("fill_valid%0d", i), aValid, 1);
    end
    applyStimulus(0, 2'b00, 4'd0, 16'h0, 0, 4'd0);
    checkOutput("fill_validDrop", aValid, 0);
    checkOutput("fill_dataHold", aData, 16'hA50F);
    checkOutput("fill_validC_lat2", cValid, 1);
    checkOutput("fill_dataC_lat2", cData, 16'hA50F);

    // Lane enables
    applyStimulus(1, 2'b11, 4'd3, 16'h1234, 0, 4'd0);
    applyStimulus(1, 2'b10, 4'd3, 16'hABCD, 0, 4'd0);
    applyStimulus(0, 2'b00, 4'd0, 16'h0, 1, 4'd3);
    checkOutput("lane_upper", aData, 16'hAB34);
    applyStimulus(1, 2'b00, 4'd3, 16'hFFFF, 0, 4'd0);
    applyStimulus(0, 2'b00, 4'd0, 16'h0, 1, 4'd3);
    checkOutput("lane_noneNoop", aData, 16'hAB34);

    // Read during write, old data (uA) versus write-through (uB)
    applyStimulus(1, 2'b11, 4'd5, 16'h1111, 0, 4'd0);
    applyStimulus(1, 2'b11, 4'd5, 16'h2222, 1, 4'd5);
    checkOutput("rdw_oldA", aData, 16'h1111);
    checkOutput("rdw_newB", bData, 16'h2222);
    applyStimulus(0, 2'b00, 4'd0, 16'h0, 1, 4'd5);
    checkOutput("rdw_afterA", aData, 16'h2222);
    applyStimulus(1, 2'b01, 4'd5, 16'h3333, 1, 4'd5);
    checkOutput("rdw_partialOldA", aData, 16'h2222);
    checkOutput("rdw_partialNewB", bData, 16'h2233);
    applyStimulus(0, 2'b00, 4'd0, 16'h0, 1, 4'd5);
    checkOutput("rdw_partialAfterA", aData, 16'h2233);

    // Out-of-range addresses on the 12-word instance
    applyStimulus(1, 2'b11, 4'd13, 16'hDEAD, 0, 4'd0);
    applyStimulus(0, 2'b00, 4'd0, 16'h0, 1, 4'd13);
    checkOutput("range_dataB13", bData, 16'h0000);
    checkOutput("range_errB13", bErr, 1);
    checkOutput("range_validB13", bValid, 1);
    checkOutput("range_dataA13", aData, 16'hDEAD);
    checkOutput("range_errA13", aErr, 0);
    applyStimulus(1, 2'b11, 4'd11, 16'h0BEE, 0, 4'd0);
    applyStimulus(0, 2'b00, 4'd0, 16'h0, 1, 4'd11);
    checkOutput("range_dataB11", bData, 16'h0BEE);
    checkOutput("range_errB11", bErr, 0);
    applyStimulus(0, 2'b00, 4'd0, 16'h0, 1, 4'd12);
    checkOutput("range_dataB12", bData, 16'h0000);
    checkOutput("range_errB12", bErr, 1);
    applyStimulus(0, 2'b00, 4'd0, 16'h0, 0, 4'd0);
    checkOutput("range_errDrop", bErr, 0);

    // Reset in the middle of a clear, with traffic held during busy
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (7) @(negedge clk);
    checkOutput("midclr_busyC", cBusy, 1);
    rst = 1'b0;
    @(negedge clk);
    we = 1'b1; wBe = 2'b11; wAddr = 4'd2; wData = 16'h7777;
    en = 1'b1; rAddr = 4'd2;
    rst = 1'b1;
    measureClear(nA, nB, nC, validSeen);
    checkOutput("midclr_cyclesC", nC, 16);
    checkOutput("midclr_cyclesA", nA, 16);
    checkOutput("midclr_noValid", validSeen, 0);

    applyStimulus(0, 2'b00, 4'd0, 16'h0, 1, 4'd2);
    checkOutput("lat2_notYetC", cValid, 0);
    checkOutput("lat2_lat1A", aValid, 1);
    checkOutput("midclr_clearedA2", aData, 16'h0000);
    applyStimulus(0, 2'b00, 4'd0, 16'h0, 1, 4'd3);
    checkOutput("lat2_validC", cValid, 1);
    checkOutput("lat2_dataC", cData, 16'h0000);
    checkOutput("lat2_errC", cErr, 0);
    checkOutput("midclr_clearedA3", aData, 16'h0000);
    applyStimulus(1, 2'b11, 4'd2, 16'h4242, 0, 4'd0);
    applyStimulus(0, 2'b00, 4'd0, 16'h0, 1, 4'd2);
    checkOutput("lat2_gapC", cValid, 0);
    applyStimulus(0, 2'b00, 4'd0, 16'h0, 0, 4'd0);
    checkOutput("lat2_validC2", cValid, 1);
    checkOutput("lat2_dataC2", cData, 16'h4242);
    applyStimulus(0, 2'b00, 4'd0, 16'h0, 0, 4'd0);
    checkOutput("lat2_strobeC", cValid, 0);
    checkOutput("lat2_holdC", cData, 16'h4242);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
